// File: rtl/mul8_seq_ctrl_pkg.sv
// Shared types and constants for the sequential 8x8 multiplier controller.
//   state_e    : controller FSM states (idle / stepping / result held)
//   step_e     : partial-product steps in execution order
//   step_shift : left shift applied to each step's 4x4 product
package mul8_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StStep = 2'd1,
        StDone = 2'd2
    } state_e;

    // Enumerator value doubles as the bit position in a step-enable mask.
    typedef enum logic [1:0] {
        StepLl = 2'd0,
        StepLh = 2'd1,
        StepHl = 2'd2,
        StepHh = 2'd3
    } step_e;

    localparam int unsigned NumSteps = 4;

    localparam int unsigned ShiftLl = 0;
    localparam int unsigned ShiftLh = 4;
    localparam int unsigned ShiftHl = 4;
    localparam int unsigned ShiftHh = 8;

    function automatic logic [3:0] step_shift(step_e s);
        logic [3:0] sh;
        sh = 4'd0;
        case (s)
            StepLl:  sh = 4'(ShiftLl);
            StepLh:  sh = 4'(ShiftLh);
            StepHl:  sh = 4'(ShiftHl);
            default: sh = 4'(ShiftHh);
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/mul4_unit.sv
// LUT-level 4x4 approximate multiplier, purely combinational.
// Built from four 2x2 blocks; each 2x2 block is exact except 3*3, which
// yields 7 instead of 9 so every block result fits in three bits.
//   a : 4-bit operand
//   b : 4-bit operand
//   p : 8-bit approximate product
module mul4_unit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [7:0] p
);

    function automatic logic [3:0] mul2(logic [1:0] x, logic [1:0] y);
        logic [3:0] r;
        r = {2'b00, x} * {2'b00, y};
        if (x == 2'b11 && y == 2'b11) begin
            r = 4'd7;
        end
        return r;
    endfunction

    logic [3:0] pp_ll;
    logic [3:0] pp_lh;
    logic [3:0] pp_hl;
    logic [3:0] pp_hh;

    always_comb begin
        pp_ll = mul2(a[1:0], b[1:0]);
        pp_lh = mul2(a[1:0], b[3:2]);
        pp_hl = mul2(a[3:2], b[1:0]);
        pp_hh = mul2(a[3:2], b[3:2]);
        p = {4'h0, pp_ll}
          + ({4'h0, pp_lh} << 2)
          + ({4'h0, pp_hl} << 2)
          + ({4'h0, pp_hh} << 4);
    end

endmodule

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 multiplier: one shared 4x4 approximate core is stepped over
// the LL, LH, HL, HH nibble products, accumulating one product per cycle.
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready/a/b : operand request channel (accepted only in idle)
//   out_valid/out_ready/p : product response channel (p held until taken)
//   busy                  : high whenever the controller is not idle
// SKIP_ZERO skips steps with a zero operand nibble; TRUNC_LL never runs LL.
module mul8_seq_ctrl
    import mul8_seq_ctrl_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1,
    parameter bit TRUNC_LL  = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] p,
    output logic        busy
);

    state_e      state_q;
    step_e       step_q;
    logic [7:0]  op_a_q;
    logic [7:0]  op_b_q;
    logic [15:0] acc_q;

    // Bit i of the mask enables step_e'(i).
    function automatic logic [3:0] step_enables(logic [7:0] x, logic [7:0] y);
        logic [3:0] en;
        en[0] = !(SKIP_ZERO && (x[3:0] == 4'h0 || y[3:0] == 4'h0)) && !TRUNC_LL;
        en[1] = !(SKIP_ZERO && (x[3:0] == 4'h0 || y[7:4] == 4'h0));
        en[2] = !(SKIP_ZERO && (x[7:4] == 4'h0 || y[3:0] == 4'h0));
        en[3] = !(SKIP_ZERO && (x[7:4] == 4'h0 || y[7:4] == 4'h0));
        return en;
    endfunction

    logic [3:0]  in_en;
    logic [3:0]  cur_en;
    logic        first_found;
    step_e       first_step;
    logic        next_found;
    step_e       next_step;
    logic [3:0]  nib_a;
    logic [3:0]  nib_b;
    logic [7:0]  core_p;
    logic [15:0] addend;

    // Nibble select: LL/LH use a_lo, HL/HH use a_hi; LL/HL use b_lo, LH/HH use b_hi.
    always_comb begin
        nib_a = (step_q == StepLl || step_q == StepLh) ? op_a_q[3:0] : op_a_q[7:4];
        nib_b = (step_q == StepLl || step_q == StepHl) ? op_b_q[3:0] : op_b_q[7:4];
    end

    mul4_unit u_mul4_unit (
        .a (nib_a),
        .b (nib_b),
        .p (core_p)
    );

    assign addend = {8'h00, core_p} << step_shift(step_q);

    // in_en picks the first step at capture; cur_en drives the walk during STEP.
    assign in_en  = step_enables(a, b);
    assign cur_en = step_enables(op_a_q, op_b_q);

    // Descending scan so the lowest qualifying step wins.
    always_comb begin
        first_found = 1'b0;
        first_step  = StepLl;
        next_found  = 1'b0;
        next_step   = StepLl;
        for (int i = 3; i >= 0; i--) begin
            if (in_en[i]) begin
                first_found = 1'b1;
                first_step  = step_e'(i[1:0]);
            end
            if (i > int'(step_q) && cur_en[i]) begin
                next_found = 1'b1;
                next_step  = step_e'(i[1:0]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            step_q  <= StepLl;
            op_a_q  <= 8'h00;
            op_b_q  <= 8'h00;
            acc_q   <= 16'h0000;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        op_a_q  <= a;
                        op_b_q  <= b;
                        acc_q   <= 16'h0000;
                        // With nothing enabled the controller still spends one
                        // STEP cycle (adding nothing) so latency is never below one.
                        step_q  <= first_found ? first_step : StepLl;
                        state_q <= StStep;
                    end
                end
                StStep: begin
                    if (cur_en[step_q]) begin
                        acc_q <= acc_q + addend;
                    end
                    if (next_found) begin
                        step_q <= next_step;
                    end else begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign p         = acc_q;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Self-checking bench: three controller instances (default, no-skip, truncated-LL)
// checked every cycle against a transaction-level model, plus directed scenarios
// with hand-computed results and latencies.
module tb_mul8_seq_ctrl;

    localparam bit SKIP_P  [3] = '{1'b1, 1'b0, 1'b1};
    localparam bit TRUNC_P [3] = '{1'b0, 1'b0, 1'b1};

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid  [3];
    logic [7:0]  a_in      [3];
    logic [7:0]  b_in      [3];
    logic        out_ready [3];
    logic        in_ready  [3];
    logic        out_valid [3];
    logic        busy      [3];
    logic [15:0] p         [3];

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 1'b0;

    // Model: 0 idle, 1 computing, 2 result held.
    int m_phase [3];
    int m_left  [3];
    int m_p     [3];

    always #5 clk = ~clk;

    mul8_seq_ctrl #(.SKIP_ZERO(1'b1), .TRUNC_LL(1'b0)) u_dut_dflt (
        .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .a(a_in[0]), .b(b_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .p(p[0]), .busy(busy[0])
    );

    mul8_seq_ctrl #(.SKIP_ZERO(1'b0), .TRUNC_LL(1'b0)) u_dut_noskip (
        .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .a(a_in[1]), .b(b_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .p(p[1]), .busy(busy[1])
    );

    mul8_seq_ctrl #(.SKIP_ZERO(1'b1), .TRUNC_LL(1'b1)) u_dut_trunc (
        .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .a(a_in[2]), .b(b_in[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
        .p(p[2]), .busy(busy[2])
    );

    // 2x2 block: exact except 3*3 -> 7.
    function automatic int ax2(int u, int v);
        return (u == 3 && v == 3) ? 7 : u * v;
    endfunction

    function automatic int core(int x, int y);
        return ax2(x % 4, y % 4) + 4 * (ax2(x % 4, y / 4) + ax2(x / 4, y % 4))
             + 16 * ax2(x / 4, y / 4);
    endfunction

    function automatic bit step_on(bit skip, bit trunc, int s, int av, int bv);
        int na;
        int nb;
        na = (s < 2) ? av % 16 : av / 16;
        nb = (s % 2 == 0) ? bv % 16 : bv / 16;
        return !(skip && (na == 0 || nb == 0)) && !(trunc && s == 0);
    endfunction

    function automatic int model_prod(bit skip, bit trunc, int av, int bv);
        int sum;
        int na;
        int nb;
        int wt;
        sum = 0;
        for (int s = 0; s < 4; s++) begin
            na = (s < 2) ? av % 16 : av / 16;
            nb = (s % 2 == 0) ? bv % 16 : bv / 16;
            wt = (s == 0) ? 1 : ((s == 3) ? 256 : 16);
            if (step_on(skip, trunc, s, av, bv)) sum += core(na, nb) * wt;
        end
        return sum % 65536;
    endfunction

    function automatic int model_lat(bit skip, bit trunc, int av, int bv);
        int cnt;
        cnt = 0;
        for (int s = 0; s < 4; s++) begin
            if (step_on(skip, trunc, s, av, bv)) cnt++;
        end
        return (cnt < 1) ? 1 : cnt;
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                m_phase[i] <= 0;
                m_left[i]  <= 0;
                m_p[i]     <= 0;
            end else begin
                case (m_phase[i])
                    0: if (in_valid[i]) begin
                        m_p[i]     <= model_prod(SKIP_P[i], TRUNC_P[i], int'(a_in[i]),
                                                 int'(b_in[i]));
                        m_left[i]  <= model_lat(SKIP_P[i], TRUNC_P[i], int'(a_in[i]),
                                                int'(b_in[i]));
                        m_phase[i] <= 1;
                    end
                    1: begin
                        m_left[i] <= m_left[i] - 1;
                        if (m_left[i] == 1) m_phase[i] <= 2;
                    end
                    default: if (out_ready[i]) m_phase[i] <= 0;
                endcase
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Per-cycle comparison against the model; p is only meaningful outside computing.
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_on) begin
                for (int i = 0; i < 3; i++) begin
                    chk($sformatf("u%0d.in_ready", i), int'(in_ready[i]), int'(m_phase[i] == 0));
                    chk($sformatf("u%0d.out_valid", i), int'(out_valid[i]),
                        int'(m_phase[i] == 2));
                    chk($sformatf("u%0d.busy", i), int'(busy[i]), int'(m_phase[i] != 0));
                    if (m_phase[i] != 1) chk($sformatf("u%0d.p", i), int'(p[i]), m_p[i]);
                end
            end
        end
    end

    task automatic wait_idle(input int i);
        int k;
        k = 0;
        while (!in_ready[i] && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk($sformatf("u%0d.idle_timeout", i), int'(in_ready[i]), 1);
    endtask

    task automatic wait_done(input int i, output int lat);
        lat = 0;
        while (!out_valid[i] && lat < 12) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic txn(input int i, input logic [7:0] av, input logic [7:0] bv,
                       input int exp_p, input int exp_lat, input string name);
        int lat;
        wait_idle(i);
        in_valid[i] = 1'b1;
        a_in[i]     = av;
        b_in[i]     = bv;
        @(posedge clk); #1;
        in_valid[i] = 1'b0;
        wait_done(i, lat);
        chk({name, ".latency"}, lat, exp_lat);
        chk({name, ".p"}, int'(p[i]), exp_p);
        out_ready[i] = 1'b1;
        @(posedge clk); #1;
        out_ready[i] = 1'b0;
        chk({name, ".in_ready_after"}, int'(in_ready[i]), 1);
    endtask

    initial begin
        int lat;
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            a_in[i]      = 8'h00;
            b_in[i]      = 8'h00;
            out_ready[i] = 1'b0;
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        cmp_on = 1'b1;

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset.u%0d.in_ready", i), int'(in_ready[i]), 1);
            chk($sformatf("reset.u%0d.out_valid", i), int'(out_valid[i]), 0);
            chk($sformatf("reset.u%0d.busy", i), int'(busy[i]), 0);
            chk($sformatf("reset.u%0d.p", i), int'(p[i]), 0);
        end

        // Pin the model with hand-computed values.
        chk("model.core_f_f", core(15, 15), 175);
        chk("model.core_5_7", core(5, 7), 35);
        chk("model.core_3_3", core(3, 3), 7);
        chk("model.prod_ff", model_prod(1'b0, 1'b0, 255, 255), 16'hC58F);
        chk("model.prod_33_trunc", model_prod(1'b1, 1'b1, 51, 51), 16'h07E0);

        txn(0, 8'h00, 8'hFF, 16'h0000, 1, "zero_skip");
        txn(0, 8'h10, 8'h10, 16'h0100, 1, "hh_only");
        txn(1, 8'hFF, 8'hFF, 16'hC58F, 4, "noskip_ff");
        txn(2, 8'h33, 8'h33, 16'h07E0, 3, "trunc_33");
        txn(0, 8'h33, 8'h33, 16'h07E7, 4, "exact_33");
        txn(2, 8'h01, 8'h01, 16'h0000, 1, "trunc_ll_only");
        txn(0, 8'h12, 8'h34, 16'h03A8, 4, "plain_12_34");

        // Backpressure: new request held throughout STEP and DONE must be ignored.
        wait_idle(0);
        in_valid[0] = 1'b1;
        a_in[0]     = 8'h12;
        b_in[0]     = 8'h34;
        @(posedge clk); #1;
        a_in[0] = 8'h56;
        b_in[0] = 8'h78;
        wait_done(0, lat);
        chk("bp.latency", lat, 4);
        for (int c = 0; c < 5; c++) begin
            chk("bp.p_hold", int'(p[0]), 16'h03A8);
            chk("bp.in_ready_low", int'(in_ready[0]), 0);
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        chk("bp.idle_in_ready", int'(in_ready[0]), 1);
        chk("bp.idle_p", int'(p[0]), 16'h03A8);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        chk("bp.next_captured", int'(busy[0]), 1);
        wait_done(0, lat);
        chk("bp.next_latency", lat, 4);
        chk("bp.next_p", int'(p[0]), 16'h2850);
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;

        // Reset during the second step aborts the operation.
        wait_idle(1);
        in_valid[1] = 1'b1;
        a_in[1]     = 8'hFF;
        b_in[1]     = 8'hFF;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        @(posedge clk); #1;
        rst          = 1'b1;
        out_ready[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort.in_ready", int'(in_ready[1]), 1);
        chk("abort.out_valid", int'(out_valid[1]), 0);
        chk("abort.p", int'(p[1]), 0);
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            chk("abort.no_result", int'(out_valid[1]), 0);
        end
        out_ready[1] = 1'b0;

        @(posedge clk); #1;
        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
